divider_nbym_ctrl: RTL

Request/response sequencer that sits directly upstream of the N-by-M restoring divider and drives its St/operand interface.
- Accepts one divide request at a time on a valid/ready handshake.
- Pulses the divider start, waits for completion and captures quotient, remainder and the one-cycle overflow strobe.
- Presents the captured result on a valid/ready response port.
- Also provides a divide-by-zero fast path and a completion timeout.

---
 rtl/divider_nbym_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/divider_nbym_ctrl.sv
// Request/response sequencer for the N-by-M restoring divider: drives St/operands,
// collects quotient/remainder/overflow, and adds a divide-by-zero fast path and a completion timeout.
module divider_nbym_ctrl #(
   parameter int DVEND_W = 16,
   parameter int DVSOR_W = 8,
   parameter int TIMEOUT = 31
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [DVEND_W-1:0] req_dividend,
   input  logic [DVSOR_W-1:0] req_divisor,
   output logic               div_st,
   output logic [DVEND_W-1:0] div_dividend,
   output logic [DVSOR_W-1:0] div_divisor,
   input  logic               div_ready,
   input  logic               div_v,
   input  logic [DVSOR_W-1:0] div_quotient,
   input  logic [DVSOR_W-1:0] div_remainder,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [DVSOR_W-1:0] rsp_quotient,
   output logic [DVSOR_W-1:0] rsp_remainder,
   output logic               rsp_ovf,
   output logic               rsp_err,
   output logic               busy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2,
      RESP      = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [DVEND_W-1:0] dvend_q, dvend_d;
   logic [DVSOR_W-1:0] dvsor_q, dvsor_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sticky_q, sticky_d;
   logic [DVSOR_W-1:0] quo_q, quo_d;
   logic [DVSOR_W-1:0] rem_q, rem_d;
   logic               ovf_q, ovf_d;
   logic               err_q, err_d;
   logic               timeout_s;

   assign timeout_s = (cnt_q == CNT_W'(TIMEOUT));

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      dvend_d  = dvend_q;
      dvsor_d  = dvsor_q;
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      ovf_d    = ovf_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               dvend_d = req_dividend;
               dvsor_d = req_divisor;
               cnt_d   = '0;
               quo_d   = '0;
               rem_d   = '0;
               err_d   = 1'b0;
               if (req_divisor == '0) begin
                  ovf_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  ovf_d   = 1'b0;
                  state_d = START;
               end
            end else begin
               state_d = IDLE;
            end
         end
         START, WAIT_DONE: begin
            // A Roth-style divider flags overflow while still Ready at load time,
            // so the sticky flag also listens during START.
            sticky_d = sticky_q | div_v;
            if (timeout_s) begin
               err_d   = 1'b1;
               ovf_d   = 1'b0;
               quo_d   = '0;
               rem_d   = '0;
               state_d = RESP;
            end else if (div_ready) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (state_q == START) begin
                  state_d = WAIT_DONE;
               end else begin
                  ovf_d   = sticky_d;
                  quo_d   = sticky_d ? '0 : div_quotient;
                  rem_d   = sticky_d ? '0 : div_remainder;
                  state_d = RESP;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               sticky_d = 1'b0;
               cnt_d    = '0;
               ovf_d    = 1'b0;
               err_d    = 1'b0;
               quo_d    = '0;
               rem_d    = '0;
               state_d  = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         dvend_q  <= '0;
         dvsor_q  <= '0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
         quo_q    <= '0;
         rem_q    <= '0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         dvend_q  <= dvend_d;
         dvsor_q  <= dvsor_d;
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   assign req_ready     = (state_q == IDLE);
   assign div_st        = (state_q == START);
   assign rsp_valid     = (state_q == RESP);
   assign busy          = (state_q != IDLE);
   assign div_dividend  = dvend_q;
   assign div_divisor   = dvsor_q;
   assign rsp_quotient  = quo_q;
   assign rsp_remainder = rem_q;
   assign rsp_ovf       = ovf_q;
   assign rsp_err       = err_q;

endmodule
